// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared constants and lowest-set-bit priority select for bus-arbitrated blocks
package reg_pkg;

    localparam int DATA_W    = 32;
    localparam int MAX_PORTS = 8;

    // found: any request bit set; idx: lowest set bit; multi: two or more bits set
    typedef struct packed {
        logic       found;
        logic [2:0] idx;
        logic       multi;
    } prio_t;

    function automatic prio_t prio_sel(input logic [MAX_PORTS-1:0] req);
        prio_t r;
        r = '0;
        // Scan downwards so the lowest set bit is the last one written
        for (int i = MAX_PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                r.idx = 3'(i);
            end
        end
        r.found = |req;
        // Clearing the lowest set bit leaves something only if more than one was set
        r.multi = |(req & (req - {{(MAX_PORTS-1){1'b0}}, 1'b1}));
        return r;
    endfunction

endpackage

// File: rtl/reg_nbuff_tri_buf.sv
// rtl/reg_nbuff_tri_buf.sv - tri-state output buffer driving one bus port
// Ports: in_i (value to drive), en_i (drive enable), bus_io (shared bus, high-Z when disabled)
module tri_buf #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_i,
    input  logic             en_i,
    inout  wire  [WIDTH-1:0] bus_io
);

    assign bus_io = en_i ? in_i : {WIDTH{1'bz}};

endmodule

// File: rtl/reg_nbuff.sv
// rtl/reg_nbuff.sv - multi-port buffered register with clear, increment, valid and sticky conflict flag
// Ports: Clk, Reset (async active-low), Bus (NPORTS bidirectional words), Load/Store (per port),
//        Clear, Inc, ErrClr, Q (contents), Valid (written since reset), Carry (increment wrap pulse),
//        Err (sticky conflict)
import reg_pkg::*;

module reg_nbuff #(
    parameter int               WIDTH     = DATA_W,
    parameter int               NPORTS    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     Clk,
    input  logic                     Reset,
    inout  wire  [NPORTS*WIDTH-1:0]  Bus,
    input  logic [NPORTS-1:0]        Load,
    input  logic [NPORTS-1:0]        Store,
    input  logic                     Clear,
    input  logic                     Inc,
    input  logic                     ErrClr,
    output logic [WIDTH-1:0]         Q,
    output logic                     Valid,
    output logic                     Carry,
    output logic                     Err
);

    logic [WIDTH-1:0]     q_q, q_d;
    logic                 valid_q, valid_d;
    logic                 carry_q, carry_d;
    logic                 err_q, err_d;

    logic [MAX_PORTS-1:0] load_all, load_ok;
    prio_t                sel_all, sel_ok;
    logic [WIDTH-1:0]     load_val;
    logic                 self_loop;
    logic                 conflict;
    logic                 unused_prio;

    // A port that loads and stores at once would capture its own output; drop it from selection
    always_comb begin
        load_all              = '0;
        load_ok               = '0;
        load_all[NPORTS-1:0]  = Load;
        load_ok[NPORTS-1:0]   = Load & ~Store;
    end

    assign sel_all     = prio_sel(load_all);
    assign sel_ok      = prio_sel(load_ok);
    assign unused_prio = ^{sel_all.idx, sel_ok.multi};

    always_comb begin
        load_val = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (sel_ok.idx == 3'(i)) begin
                load_val = Bus[i*WIDTH +: WIDTH];
            end
        end
    end

    assign self_loop = |(Load & Store);
    // Raw Load (including ignored self-loops) counts towards the Inc collision
    assign conflict  = sel_all.multi | self_loop | ((Clear | sel_all.found) & Inc);

    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        carry_d = 1'b0;
        if (Clear) begin
            q_d     = '0;
            valid_d = 1'b1;
        end else if (sel_ok.found) begin
            q_d     = load_val;
            valid_d = 1'b1;
        end else if (Inc) begin
            q_d     = q_q + {{(WIDTH-1){1'b0}}, 1'b1};
            carry_d = &q_q;
        end
        // A new conflict beats a simultaneous ErrClr
        err_d = conflict | (err_q & ~ErrClr);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            q_q     <= RESET_VAL;
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    // Drivers are gated by Reset so every bus floats while reset is held
    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        tri_buf #(.WIDTH(WIDTH)) u_buf (
            .in_i   (q_q),
            .en_i   (Store[g] & Reset),
            .bus_io (Bus[g*WIDTH +: WIDTH])
        );
    end

    assign Q     = q_q;
    assign Valid = valid_q;
    assign Carry = carry_q;
    assign Err   = err_q;

endmodule

// File: tb/tb_reg_nbuff.sv
// tb/tb_reg_nbuff.sv - directed scoreboard bench for reg_nbuff
module tb_reg_nbuff;

    localparam int W = 32;
    localparam int N = 3;

    logic           Clk = 1'b0;
    logic           Reset;
    wire  [N*W-1:0] Bus;
    logic [N-1:0]   Load, Store;
    logic           Clear, Inc, ErrClr;
    logic [W-1:0]   Q;
    logic           Valid, Carry, Err;

    logic [W-1:0]   drv_val [N];
    logic [N-1:0]   drv_en;

    logic [W-1:0]   sb [$];
    logic [W-1:0]   exp_v;
    int             n_assert = 0;
    int             n_fail   = 0;

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < N; g++) begin : g_drv
        assign Bus[g*W +: W] = drv_en[g] ? drv_val[g] : {W{1'bz}};
    end

    reg_nbuff #(.WIDTH(W), .NPORTS(N), .RESET_VAL('0)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Bus    (Bus),
        .Load   (Load),
        .Store  (Store),
        .Clear  (Clear),
        .Inc    (Inc),
        .ErrClr (ErrClr),
        .Q      (Q),
        .Valid  (Valid),
        .Carry  (Carry),
        .Err    (Err)
    );

    function automatic logic [W-1:0] bus_word(input int p);
        logic [N*W-1:0] b;
        b = Bus;
        return b[p*W +: W];
    endfunction

    // A floating bus reads as Z in a four-state simulator and as 0 in a two-state one
    function automatic logic [W-1:0] is_hiz(input logic [W-1:0] w);
        return ((w === {W{1'bz}}) || (w === '0)) ? 32'd1 : 32'd0;
    endfunction

    task automatic expect_val(input logic [W-1:0] v);
        sb.push_back(v);
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs);
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: observed %h with no expected value queued", tag, obs);
        end else begin
            exp_v = sb.pop_front();
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic load_port(input int p, input logic [W-1:0] v);
        drv_val[p] = v;
        drv_en[p]  = 1'b1;
        Load       = N'(1) << p;
        tick();
        Load       = '0;
        drv_en[p]  = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; Load = '0; Store = '0; Clear = 1'b0; Inc = 1'b0; ErrClr = 1'b0;
        drv_en = '0;
        for (int i = 0; i < N; i++) drv_val[i] = '0;
        #12;
        expect_val(32'h0); check("rst_q", Q);
        expect_val(32'h0); check("rst_valid", 32'(Valid));
        expect_val(32'h0); check("rst_err", 32'(Err));
        expect_val(32'h0); check("rst_carry", 32'(Carry));
        Reset = 1'b1;
        tick();

        // Async reset mid-cycle while storing 0x55 on port 1
        load_port(0, 32'h55);
        Store = 3'b010;
        #1;
        expect_val(32'h55); check("pre_rst_bus1", bus_word(1));
        expect_val(32'h1);  check("pre_rst_valid", 32'(Valid));
        #2;
        Reset = 1'b0;
        #1;
        expect_val(32'h0); check("async_rst_q", Q);
        expect_val(32'h1); check("async_rst_bus1_hiz", is_hiz(bus_word(1)));
        expect_val(32'h0); check("async_rst_valid", 32'(Valid));
        expect_val(32'h0); check("async_rst_err", 32'(Err));
        Store = '0;
        Reset = 1'b1;
        tick();

        // Load port 0 then store onto ports 1 and 2
        load_port(0, 32'h1234);
        Store = 3'b110;
        #1;
        expect_val(32'h1234); check("ld_q", Q);
        expect_val(32'h1);    check("ld_valid", 32'(Valid));
        expect_val(32'h1234); check("st_bus1", bus_word(1));
        expect_val(32'h1234); check("st_bus2", bus_word(2));
        expect_val(32'h1);    check("st_bus0_hiz", is_hiz(bus_word(0)));
        Store = '0;

        // Two loads at once: lowest index wins, Err set; ErrClr clears it
        drv_val[0] = 32'hA; drv_val[2] = 32'hB; drv_en = 3'b101; Load = 3'b101;
        tick();
        Load = '0; drv_en = '0;
        #1;
        expect_val(32'hA); check("multi_ld_q", Q);
        expect_val(32'h1); check("multi_ld_err", 32'(Err));
        ErrClr = 1'b1;
        tick();
        ErrClr = 1'b0;
        #1;
        expect_val(32'h0); check("errclr_err", 32'(Err));

        // Register-to-register transfer: store port 0 while loading port 1
        load_port(0, 32'h7);
        Store = 3'b001; drv_val[1] = 32'h99; drv_en = 3'b010; Load = 3'b010;
        #1;
        expect_val(32'h7); check("xfer_bus0_old", bus_word(0));
        tick();
        Load = '0; Store = '0; drv_en = '0;
        #1;
        expect_val(32'h99); check("xfer_q_new", Q);
        expect_val(32'h0);  check("xfer_err", 32'(Err));

        // Increment wrap and carry pulse
        load_port(0, 32'hFFFF_FFFF);
        Inc = 1'b1;
        tick();
        #1;
        expect_val(32'h0); check("wrap_q", Q);
        expect_val(32'h1); check("wrap_carry", 32'(Carry));
        tick();
        Inc = 1'b0;
        #1;
        expect_val(32'h1); check("inc2_q", Q);
        expect_val(32'h0); check("inc2_carry", 32'(Carry));
        tick();
        #1;
        expect_val(32'h1); check("hold_q", Q);

        // Clear beats Load beats Inc, and the collision is flagged
        drv_val[0] = 32'h77; drv_en = 3'b001; Load = 3'b001; Clear = 1'b1; Inc = 1'b1;
        tick();
        Load = '0; drv_en = '0; Clear = 1'b0; Inc = 1'b0;
        #1;
        expect_val(32'h0); check("clr_q", Q);
        expect_val(32'h1); check("clr_valid", 32'(Valid));
        expect_val(32'h1); check("clr_inc_err", 32'(Err));
        expect_val(32'h0); check("clr_no_carry", 32'(Carry));
        ErrClr = 1'b1;
        tick();
        ErrClr = 1'b0;

        // Self-loop on port 2: load ignored, drive kept, conflict flagged
        load_port(0, 32'h5);
        #1;
        expect_val(32'h0); check("pre_loop_err", 32'(Err));
        Load = 3'b100; Store = 3'b100;
        #1;
        expect_val(32'h5); check("loop_bus2", bus_word(2));
        tick();
        Load = '0; Store = '0;
        #1;
        expect_val(32'h5); check("loop_q", Q);
        expect_val(32'h1); check("loop_err", 32'(Err));

        // Conflict in the same cycle as ErrClr keeps Err set
        drv_val[0] = 32'h3; drv_val[1] = 32'h4; drv_en = 3'b011; Load = 3'b011; ErrClr = 1'b1;
        tick();
        Load = '0; drv_en = '0; ErrClr = 1'b0;
        #1;
        expect_val(32'h3); check("errclr_conf_q", Q);
        expect_val(32'h1); check("errclr_conf_err", 32'(Err));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_nbuff.md
# reg_nbuff

Parametrised general-purpose CPU register with NPORTS independent bidirectional bus ports, each with its own tri-state output buffer. It generalises the two-port buffered register to arbitrary width and port count, and adds clear, increment with carry-out, a valid flag, and sticky conflict detection. It sits on the datapath buses, where it serves as a GPR, PC or MAR.

## Interface
- WIDTH, 32: data width per bus, ≥ 2.
- NPORTS, 2: number of bus ports, 1 to 8.
- RESET_VAL, 0: register contents after reset.

Ports (clock and reset first):
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Bus  inout  NPORTS*WIDTH  bus i occupies bits [i*WIDTH +: WIDTH]; high-Z unless driven.
- Load  in  NPORTS  Load[i]=1 captures bus i at the next edge.
- Store  in  NPORTS  Store[i]=1 drives Q onto bus i.
- Clear  in  1  synchronous clear to 0.
- Inc  in  1  synchronous increment by 1.
- ErrClr  in  1  clears Err at the next edge.
- Q  out  WIDTH  register contents.
- Valid  out  1  register has been written since reset.
- Carry  out  1  one-cycle pulse after Inc wraps all-ones to 0.
- Err  out  1  sticky conflict flag.

## Operation
- Reset asserted (Reset=0) sets, immediately and regardless of Clk: Q=RESET_VAL, Valid=0, Carry=0, Err=0, and all buses high-Z. Reset has effect mid-operation; there is no partial update.
- Update priority per edge is Clear > Load > Inc > hold.
  - Clear: Q=0, Valid=1.
  - Load: Q=Bus[k], where k is the lowest index with Load[k]=1 and Store[k]=0. Valid=1.
  - Inc: Q=Q+1 modulo 2^WIDTH. Valid is unchanged.
- Carry is registered. It is 1 for exactly the cycle after an edge where Inc was applied (not overridden) and Q was all-ones; otherwise it is 0.
- Store is combinational: bus i = Q while Store[i]=1, else high-Z. Multiple ports may be stored at once.
- Load[i] together with Store[i] on the same port is a self-loop. That port's load is ignored (the drive still occurs) and the event is a conflict.
- Conflict events that set Err at the edge:
  - more than one Load bit is set;
  - Load[i] and Store[i] are set on the same port;
  - Clear or Load coincides with Inc.
- Err clears only on reset or ErrClr. If a new conflict occurs in the same cycle as ErrClr, the conflict wins and Err stays 1.
- Load sampled while its bus is high-Z captures X; this is not checked by the block.

## Timing
- Load, Clear and Inc have 1-cycle latency: Q reflects the operation after the edge that samples it.
- Store has zero cycles of latency. The bus is driven in the same cycle Q is valid and tracks Q after an update.
- Store on port i and Load on port j≠i in the same cycle is a legal register-to-register transfer. The old Q is driven; the new value appears after the edge.
- Valid and Err are registered and change only on an edge or reset.
- Reset deassertion takes effect at the next edge. No synchroniser is inside the block.

## Structure
- Shared package `reg_pkg` holds:
  - the default width constant (DATA_W=32);
  - the priority-select function (lowest-set-bit encoder returning index and a multi-hot flag), which is reused by other bus-arbitrated blocks.
- Sub-module `tri_buf` (WIDTH param; in, en, inout bus) is instantiated NPORTS times with a generate loop.
- The remaining logic (priority mux, incrementer, flags) is flat in reg_nbuff.

## Test plan
Default parameters for all scenarios are WIDTH=32, NPORTS=3.
- Reset (Reset=0) mid-cycle while Store[1]=1 and Q=0x55 -> Q=0, bus 1 high-Z immediately, Valid=0, Err=0.
- Bus0=0x1234 with Load=3'b001 for one edge, then Store=3'b110 -> Q=0x1234, Valid=1, buses 1 and 2 read 0x1234, bus 0 high-Z.
- Bus0=0xA, Bus2=0xB, Load=3'b101 -> Q=0xA, Err=1 after the edge. ErrClr for one edge -> Err=0.
- Q=0x0000_0007, Store=3'b001, Load=3'b010 with Bus1 externally driven to 0x99 -> bus 0 reads 0x7 that cycle, Q=0x99 after the edge, Err=0.
- Load 0xFFFF_FFFF, then Inc for 2 edges -> Q=0 with Carry=1 for one cycle, then Q=1 with Carry=0.
- Clear+Inc+Load[0] in the same cycle -> Q=0, Valid=1, Err=1. Load[2]+Store[2] -> Q unchanged, Err=1.
